gb_stream_reader: RTL and testbench

- Read-side initiator for the accelerator's global buffer.
- On a start command it issues a strided sequence of read requests to the global buffer interface and collects the returned interface-wide words.
- Returned words pass through a credit-limited FIFO and leave on a valid/ready stream toward the PE array.
- Sits between the global buffer and the PE-array ifmap/filter distribution logic.

---
 rtl/gb_stream_reader.sv | 124 ++++++++++++
 tb/tb_gb_stream_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_stream_reader.sv
// Global-buffer read initiator: issues a strided run of reads, queues the returned
// interface words in a credit-limited FIFO and streams them out in issue order.
module gb_stream_reader #(
  parameter int globalBufferSize          = 1024,
  parameter int globalBufferInterfaceSize = 16,
  parameter int dataSize                  = 8,
  parameter int fifoDepth                 = 4,
  parameter int lengthWidth               = 16,
  localparam int AW = $clog2(globalBufferSize),
  localparam int DW = globalBufferInterfaceSize * dataSize,
  localparam int PW = $clog2(fifoDepth),
  localparam int CW = PW + 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start_i,
  input  logic [AW-1:0]          base_addr_i,
  input  logic [AW-1:0]          stride_i,
  input  logic [lengthWidth-1:0] length_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [AW-1:0]          gb_addr_o,
  output logic                   gb_rd_en_o,
  input  logic [DW-1:0]          gb_rd_data_i,
  input  logic                   gb_valid_i,
  output logic [DW-1:0]          out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [CW:0] DEPTH = (CW+1)'(fifoDepth);

  state_t                 state;
  logic [AW-1:0]          stride_q;
  logic [lengthWidth-1:0] length_q, issued;
  logic [CW-1:0]          outstanding, fifo_count;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [DW-1:0]          mem [fifoDepth];
  logic [CW:0]            used;
  logic                   has_credit, issue_now, push, pop, spurious;

  // A read holds its FIFO slot from the moment it is issued, so the FIFO cannot overflow.
  assign used       = {1'b0, fifo_count} + {1'b0, outstanding};
  assign has_credit = used < DEPTH;
  assign issue_now  = ((state == IDLE) && start_i && (length_i != '0)) ||
                      ((state == ISSUE) && has_credit);
  assign push       = gb_valid_i && busy_o && (outstanding != '0);
  assign spurious   = gb_valid_i && busy_o && (outstanding == '0);
  assign pop        = out_valid_o && out_ready_i;

  assign out_valid_o = fifo_count != '0;
  assign out_data_o  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      gb_rd_en_o  <= 1'b0;
      gb_addr_o   <= '0;
      stride_q    <= '0;
      length_q    <= '0;
      issued      <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      done_o     <= 1'b0;
      gb_rd_en_o <= issue_now;
      case (state)
        IDLE: if (start_i) begin
          stride_q  <= stride_i;
          length_q  <= length_i;
          err_o     <= 1'b0;
          gb_addr_o <= base_addr_i;
          issued    <= lengthWidth'(1);
          if (length_i == '0) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            busy_o <= 1'b1;
            state  <= (length_i == lengthWidth'(1)) ? DRAIN : ISSUE;
          end
        end
        ISSUE: if (has_credit) begin
          gb_addr_o <= gb_addr_o + stride_q;
          issued    <= issued + lengthWidth'(1);
          if (issued + lengthWidth'(1) == length_q) state <= DRAIN;
        end
        DRAIN: if ((outstanding == '0) && (fifo_count == '0)) begin
          state  <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (spurious) err_o <= 1'b1;

      case ({issue_now, push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gb_rd_data_i;
  end

  always_ff @(posedge clk) begin
    if (nrst) assert (!(push && !pop && (fifo_count == CW'(fifoDepth))));
  end
endmodule

// File: tb/tb_gb_stream_reader.sv
// Directed bench for gb_stream_reader: a global-buffer responder with adjustable
// latency, a queue-based reference of the expected read/beat sequence, and per-cycle checks.
`timescale 1ns/1ps
module tb_gb_stream_reader;
  localparam int AW = 10;
  localparam int DW = 128;
  localparam int GBS = 1024;

  logic          clk = 1'b0, nrst = 1'b0, start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0, stride_i = '0;
  logic [15:0]   length_i = '0;
  logic          busy_o, done_o, err_o, gb_rd_en_o, gb_valid_i, out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [AW-1:0] gb_addr_o;
  logic [DW-1:0] gb_rd_data_i, out_data_o;

  gb_stream_reader dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .base_addr_i(base_addr_i),
    .stride_i(stride_i), .length_i(length_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .gb_addr_o(gb_addr_o), .gb_rd_en_o(gb_rd_en_o),
    .gb_rd_data_i(gb_rd_data_i), .gb_valid_i(gb_valid_i), .out_data_o(out_data_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
  );

  always #5 clk = ~clk;

  int nvec = 0, nmis = 0;

  function automatic logic [DW-1:0] gbdata(input logic [AW-1:0] a);
    logic [15:0] w;
    w = {6'b0, a} ^ 16'hA5A5;
    return {8{w}};
  endfunction

  task automatic chk_b(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin nmis++; $display("FAIL %s: got %b expected %b", nm, act, exp); end
  endtask
  task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin nmis++; $display("FAIL %s: got %h expected %h", nm, act, exp); end
  endtask
  task automatic chk_i(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin nmis++; $display("FAIL %s: got %0d expected %0d", nm, act, exp); end
  endtask

  // reference state
  int cyc = 0, lat = 1, pend = 0, mo = 0, st_cyc = 0;
  int rd_cnt = 0, beat_cnt = 0, done_cnt = 0;
  bit spur_req = 0, act = 0, rstchk = 0, err_exp = 0, pv = 0, phs = 0, e0;
  logic [DW-1:0] pd;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            rq_due[$];
  logic [AW-1:0] rq_addr[$];
  logic [AW-1:0] addr_log[16];
  int            rel_log[16];
  logic [DW-1:0] beat_log[16];

  always @(negedge clk) begin
    cyc++;
    e0 = (pend == 2);
    if (pend == 1) act = 1;
    pend = 0;
    if (rstchk) begin
      chk_b("rst_busy", busy_o, 1'b0);
      chk_b("rst_done", done_o, 1'b0);
      chk_b("rst_rd_en", gb_rd_en_o, 1'b0);
      chk_b("rst_valid", out_valid_o, 1'b0);
      chk_w("rst_addr", DW'(gb_addr_o), '0);
      rstchk = 0;
    end
    chk_b("err", err_o, err_exp);
    chk_b("busy", busy_o, act && !done_o);
    if (done_o || e0) chk_b("done", done_o, act || e0);
    if (done_o) begin
      if (act) begin
        chk_i("done_beats_left", exp_q.size(), 0);
        chk_i("done_reads_left", addr_q.size(), 0);
        act = 0;
      end
      done_cnt++;
    end
    if (gb_rd_en_o) begin
      nvec++;
      if (addr_q.size() == 0) begin nmis++; $display("FAIL rd_extra: read at %0d beyond length", gb_addr_o); end
      else begin
        nvec--;
        chk_w("rd_addr", DW'(gb_addr_o), DW'(addr_q.pop_front()));
      end
      if (rd_cnt < 16) begin addr_log[rd_cnt] = gb_addr_o; rel_log[rd_cnt] = cyc - st_cyc; end
      rd_cnt++;
      rq_due.push_back(cyc + lat);
      rq_addr.push_back(gb_addr_o);
      if (act) mo++;
    end
    if (pv && !phs) begin
      chk_b("hold_valid", out_valid_o, 1'b1);
      chk_w("hold_data", out_data_o, pd);
    end
    if (out_valid_o) begin
      if (exp_q.size() == 0) begin nvec++; nmis++; $display("FAIL beat_extra: got %h expected none", out_data_o); end
      else begin
        chk_w("beat", out_data_o, exp_q[0]);
        if (out_ready_i) begin
          void'(exp_q.pop_front());
          if (beat_cnt < 16) beat_log[beat_cnt] = out_data_o;
          beat_cnt++;
        end
      end
    end
    pv = out_valid_o; phs = out_valid_o && out_ready_i; pd = out_data_o;
    if (nrst && start_i && !act && !done_o) begin
      for (int k = 0; k < int'(length_i); k++) begin
        addr_q.push_back(AW'((int'(base_addr_i) + k * int'(stride_i)) % GBS));
        exp_q.push_back(gbdata(AW'((int'(base_addr_i) + k * int'(stride_i)) % GBS)));
      end
      pend = (length_i == 0) ? 2 : 1;
      err_exp = 0; rd_cnt = 0; beat_cnt = 0; st_cyc = cyc;
    end
    // global buffer responder: returns in request order after lat cycles
    gb_valid_i = 1'b0; gb_rd_data_i = '0;
    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      gb_valid_i = 1'b1;
      gb_rd_data_i = gbdata(rq_addr.pop_front());
      void'(rq_due.pop_front());
      if (act && mo > 0) mo--;
    end else if (spur_req) begin
      gb_valid_i = 1'b1;
      gb_rd_data_i = {DW{1'b1}};
      if (act && mo == 0) err_exp = 1;
      spur_req = 0;
    end
    if (!nrst) begin
      act = 0; pend = 0; mo = 0; err_exp = 0; rstchk = 1; pv = 0;
      exp_q.delete(); addr_q.delete();
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(input int b, input int s, input int l);
    base_addr_i = AW'(b); stride_i = AW'(s); length_i = 16'(l); start_i = 1'b1;
    cycle(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0;
    bit hit;
    d0 = done_cnt; hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      cycle(1);
      if (done_cnt > d0) hit = 1;
    end
    nvec++;
    if (!hit) begin nmis++; $display("FAIL %s: done_o not seen within %0d cycles", nm, budget); end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    cycle(3);
    nrst = 1'b1;
    cycle(1);
    chk_b("reset_busy", busy_o, 1'b0);
    chk_b("reset_err", err_o, 1'b0);

    // basic stream, latency 1
    lat = 1; out_ready_i = 1'b1; d0 = done_cnt;
    do_start(0, 16, 4);
    chk_b("t1_first_rd_en", gb_rd_en_o, 1'b1);
    chk_w("t1_first_addr", DW'(gb_addr_o), '0);
    wait_done("t1_done", 60);
    for (int k = 0; k < 4; k++) begin
      chk_w("t1_addr_seq", DW'(addr_log[k]), DW'(k * 16));
      chk_i("t1_addr_cycle", rel_log[k], k + 1);
    end
    chk_i("t1_beats", beat_cnt, 4);
    chk_i("t1_done_once", done_cnt, d0 + 1);
    chk_w("t1_beat3_data", beat_log[3], 128'hA595A595A595A595A595A595A595A595);
    chk_b("t1_busy_low", busy_o, 1'b0);

    // wrap-around
    do_start(1008, 16, 3);
    wait_done("t2_done", 60);
    chk_w("t2_addr0", DW'(addr_log[0]), DW'(1008));
    chk_w("t2_addr1", DW'(addr_log[1]), DW'(0));
    chk_w("t2_addr2", DW'(addr_log[2]), DW'(16));
    chk_w("t2_beat0_data", beat_log[0], 128'hA655A655A655A655A655A655A655A655);
    chk_w("t2_beat1_data", beat_log[1], 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5);

    // backpressure
    lat = 3; out_ready_i = 1'b0;
    do_start(100, 5, 8);
    cycle(20);
    chk_i("t3_reads_stalled", rd_cnt, 4);
    chk_b("t3_rd_en_low", gb_rd_en_o, 1'b0);
    chk_b("t3_valid_held", out_valid_o, 1'b1);
    out_ready_i = 1'b1;
    wait_done("t3_done", 100);
    chk_i("t3_beats", beat_cnt, 8);
    chk_b("t3_err", err_o, 1'b0);
    chk_w("t3_beat0_data", beat_log[0], 128'hA5C1A5C1A5C1A5C1A5C1A5C1A5C1A5C1);
    chk_w("t3_beat7_data", beat_log[7], 128'hA522A522A522A522A522A522A522A522);

    // length zero
    lat = 1; d0 = done_cnt;
    do_start(5, 1, 0);
    chk_b("t4_done", done_o, 1'b1);
    chk_b("t4_busy", busy_o, 1'b0);
    cycle(3);
    chk_i("t4_no_reads", rd_cnt, 0);
    chk_i("t4_done_once", done_cnt, d0 + 1);

    // spurious return in DRAIN, start while busy
    out_ready_i = 1'b0;
    do_start(40, 2, 3);
    base_addr_i = 10'd500; length_i = 16'd7; start_i = 1'b1;
    cycle(1);
    start_i = 1'b0;
    cycle(8);
    spur_req = 1;
    cycle(3);
    chk_b("t5_err_set", err_o, 1'b1);
    out_ready_i = 1'b1;
    wait_done("t5_done", 60);
    chk_i("t5_reads", rd_cnt, 3);
    chk_i("t5_beats", beat_cnt, 3);
    cycle(3);
    chk_b("t5_err_sticky", err_o, 1'b1);

    // reset mid-transfer
    lat = 4; d0 = done_cnt;
    do_start(200, 3, 6);
    for (int i = 0; i < 20 && rd_cnt < 2; i++) cycle(1);
    nrst = 1'b0;
    cycle(1);
    nrst = 1'b1;
    chk_b("t6_busy", busy_o, 1'b0);
    chk_b("t6_rd_en", gb_rd_en_o, 1'b0);
    chk_b("t6_valid", out_valid_o, 1'b0);
    chk_b("t6_err_cleared", err_o, 1'b0);
    cycle(12);
    chk_b("t6_late_err", err_o, 1'b0);
    chk_i("t6_no_done", done_cnt, d0);
    lat = 1;
    do_start(7, 9, 2);
    wait_done("t6_restart_done", 60);
    chk_i("t6_restart_beats", beat_cnt, 2);
    chk_b("t6_restart_err", err_o, 1'b0);

    cycle(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
